// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver running on the system clock: synchronises and
// deglitches the bus, decodes start/data/parity/stop and reports code or error pulses.
`timescale 1ns/1ps
module ps2_rx_frame #(
    parameter int DATA_BITS      = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ps2c,
    input  logic                 ps2d,
    input  logic                 en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 timeout_err,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FCW = $clog2(FILTER_LEN + 1);

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
    localparam logic [BCW-1:0] BIT_ZERO  = BCW'(0);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [TCW-1:0] TO_ONE    = TCW'(1);
    localparam logic [TCW-1:0] TO_ZERO   = TCW'(0);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [FCW-1:0] FILT_ONE  = FCW'(1);
    localparam logic [FCW-1:0] FILT_ZERO = FCW'(0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        odd_parity_ok = ^{d, p};
    endfunction

    logic [SYNC_STAGES-1:0] c_sync_r;
    logic [SYNC_STAGES-1:0] d_sync_r;
    logic                   c_s;
    logic                   d_s;
    logic                   filt_c_r;
    logic                   filt_prev_r;
    logic [FCW-1:0]         filt_cnt_r;
    logic                   fall_s;

    state_t                 state_r;
    logic [BCW-1:0]         bit_cnt_r;
    logic [TCW-1:0]         to_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic [DATA_BITS-1:0]   shift_nxt_s;
    logic                   par_r;
    logic [DATA_BITS-1:0]   data_out_r;
    logic                   data_valid_r;
    logic                   parity_err_r;
    logic                   frame_err_r;
    logic                   timeout_err_r;
    logic                   busy_r;

    // Two-line synchroniser chains, idle-high after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync_r <= {SYNC_STAGES{1'b1}};
            d_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            c_sync_r <= {c_sync_r[SYNC_STAGES-2:0], ps2c};
            d_sync_r <= {d_sync_r[SYNC_STAGES-2:0], ps2d};
        end
    end

    assign c_s = c_sync_r[SYNC_STAGES-1];
    assign d_s = d_sync_r[SYNC_STAGES-1];

    // Clock deglitcher: follow the synchronised clock only after FILTER_LEN differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_c_r    <= 1'b1;
            filt_prev_r <= 1'b1;
            filt_cnt_r  <= FILT_ZERO;
        end else begin
            filt_prev_r <= filt_c_r;
            if (c_s != filt_c_r) begin
                if (filt_cnt_r == FILT_LAST) begin
                    filt_c_r   <= c_s;
                    filt_cnt_r <= FILT_ZERO;
                end else begin
                    filt_c_r   <= filt_c_r;
                    filt_cnt_r <= filt_cnt_r + FILT_ONE;
                end
            end else begin
                filt_c_r   <= filt_c_r;
                filt_cnt_r <= FILT_ZERO;
            end
        end
    end

    assign fall_s = filt_prev_r & ~filt_c_r;

    // New data bits enter at the top so the first bit ends up in bit 0.
    generate
        if (DATA_BITS > 1) begin : g_shift_wide
            assign shift_nxt_s = {d_s, shift_r[DATA_BITS-1:1]};
        end else begin : g_shift_one
            assign shift_nxt_s = d_s;
        end
    endgenerate

    // Frame FSM with timeout; all outputs and pulses are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            bit_cnt_r     <= BIT_ZERO;
            to_cnt_r      <= TO_ZERO;
            shift_r       <= {DATA_BITS{1'b0}};
            par_r         <= 1'b0;
            data_out_r    <= {DATA_BITS{1'b0}};
            data_valid_r  <= 1'b0;
            parity_err_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            timeout_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            data_valid_r  <= 1'b0;
            parity_err_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            timeout_err_r <= 1'b0;
            if (!en) begin
                state_r   <= S_IDLE;
                busy_r    <= 1'b0;
                bit_cnt_r <= BIT_ZERO;
                to_cnt_r  <= TO_ZERO;
            end else if (fall_s) begin
                to_cnt_r <= TO_ZERO;
                case (state_r)
                    S_IDLE: begin
                        bit_cnt_r <= BIT_ZERO;
                        if (!d_s) begin
                            state_r <= S_DATA;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        shift_r   <= shift_nxt_s;
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        busy_r    <= 1'b1;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= S_PARITY;
                        end else begin
                            state_r <= S_DATA;
                        end
                    end
                    S_PARITY: begin
                        par_r   <= d_s;
                        state_r <= S_STOP;
                        busy_r  <= 1'b1;
                    end
                    S_STOP: begin
                        state_r      <= S_IDLE;
                        busy_r       <= 1'b0;
                        bit_cnt_r    <= BIT_ZERO;
                        frame_err_r  <= ~d_s;
                        parity_err_r <= ~odd_parity_ok(shift_r, par_r);
                        if (d_s && odd_parity_ok(shift_r, par_r)) begin
                            data_out_r   <= shift_r;
                            data_valid_r <= 1'b1;
                        end else begin
                            data_out_r   <= data_out_r;
                            data_valid_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r   <= S_IDLE;
                        busy_r    <= 1'b0;
                        bit_cnt_r <= BIT_ZERO;
                    end
                endcase
            end else if (state_r != S_IDLE) begin
                // A fall in the expiry cycle is handled above, so it always beats the timeout.
                if (to_cnt_r == TO_LAST) begin
                    timeout_err_r <= 1'b1;
                    state_r       <= S_IDLE;
                    busy_r        <= 1'b0;
                    bit_cnt_r     <= BIT_ZERO;
                    to_cnt_r      <= TO_ZERO;
                end else begin
                    to_cnt_r <= to_cnt_r + TO_ONE;
                end
            end else begin
                to_cnt_r <= TO_ZERO;
            end
        end
    end

    assign data_out    = data_out_r;
    assign data_valid  = data_valid_r;
    assign parity_err  = parity_err_r;
    assign frame_err   = frame_err_r;
    assign timeout_err = timeout_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: randomized and directed PS/2 frames, expected
// events queued by a reference model and popped by an independent output monitor.
`timescale 1ns/1ps
module tb_ps2_rx_frame;

    localparam int DB   = 8;
    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int TO   = 400;
    localparam int HP   = 40;

    logic          clk;
    logic          rst_n;
    logic          ps2c;
    logic          ps2d;
    logic          en;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          timeout_err;
    logic          busy;

    ps2_rx_frame #(
        .DATA_BITS(DB), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ps2c(ps2c), .ps2d(ps2d), .en(en),
        .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .timeout_err(timeout_err), .busy(busy)
    );

    typedef struct {
        bit            v;
        bit            pe;
        bit            fe;
        bit            te;
        logic [DB-1:0] d;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    logic [DB-1:0] model_dout;
    int            cmp_cnt = 0;
    int            err_cnt = 0;
    int            cyc = 0;
    int            last_fall_cyc = 0;
    int            to_seen_cyc = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (data_valid || parity_err || frame_err || timeout_err)) begin
            if (timeout_err) to_seen_cyc = cyc;
            if (q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_pulse: v=%0b pe=%0b fe=%0b te=%0b expected none (cycle %0d)",
                         data_valid, parity_err, frame_err, timeout_err, cyc);
            end else begin
                mon_e = q.pop_front();
                check("data_valid", 32'(data_valid), 32'(mon_e.v));
                check("parity_err", 32'(parity_err), 32'(mon_e.pe));
                check("frame_err", 32'(frame_err), 32'(mon_e.fe));
                check("timeout_err", 32'(timeout_err), 32'(mon_e.te));
                check("data_out_at_pulse", 32'(data_out), 32'(mon_e.d));
            end
        end
    end

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2d = b;
        if (glitch) begin
            tick(HP / 2);
            ps2c = 1'b0;
            tick(FILT - 1);
            ps2c = 1'b1;
            tick(HP / 2);
        end else begin
            tick(HP);
        end
        ps2c = 1'b0;
        last_fall_cyc = cyc;
        tick(HP);
        ps2c = 1'b1;
    endtask

    // Sends the first nbits of start/data/parity/stop; full frames queue their expected outcome.
    task automatic send_frame(input logic [DB-1:0] code, input logic par, input logic stop,
                              input int nbits, input bit glitch);
        logic [DB+2:0] bits;
        bit            ok;
        exp_t          e;
        bits = {stop, par, code, 1'b0};
        if (nbits == DB + 3) begin
            ok = (($countones(code) + int'(par)) % 2) == 1;
            if (stop && ok) model_dout = code;
            e.v = stop && ok; e.pe = !ok; e.fe = !stop; e.te = 1'b0; e.d = model_dout;
            q.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(bits[i], glitch && (i == 3));
            if (i == 0) check("busy_after_start", 32'(busy), 32'd1);
        end
        ps2d = 1'b1;
        tick(2 * HP);
        if (nbits == DB + 3) begin
            check("busy_after_frame", 32'(busy), 32'd0);
            check("data_out_hold", 32'(data_out), 32'(model_dout));
        end
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while (q.size() != 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
    endtask

    function automatic logic good_par(input logic [DB-1:0] c);
        return ($countones(c) % 2) == 0;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        e;
        logic [DB-1:0] code;
        logic        par;
        logic        stop;
        int          lat;
        rst_n = 1'b0; en = 1'b1; ps2c = 1'b1; ps2d = 1'b1;
        model_dout = '0;
        tick(3);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(2 * HP);

        // Directed test-plan frames.
        send_frame(8'h1C, 1'b0, 1'b1, DB + 3, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b1, DB + 3, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b1, DB + 3, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, DB + 3, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0, DB + 3, 1'b0);

        // Timeout after start plus four data bits.
        send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b0);
        e.v = 1'b0; e.pe = 1'b0; e.fe = 1'b0; e.te = 1'b1; e.d = model_dout;
        q.push_back(e);
        to_seen_cyc = -1;
        wait_drain(TO + 100);
        lat = to_seen_cyc - last_fall_cyc;
        check("timeout_latency_window",
              32'((lat >= TO + SYNC + FILT - 1) && (lat <= TO + SYNC + FILT + 3)), 32'd1);
        check("busy_after_timeout", 32'(busy), 32'd0);
        send_frame(8'h29, 1'b0, 1'b1, DB + 3, 1'b0);

        // Glitches while idle and inside a frame.
        ps2c = 1'b0; tick(FILT - 1); ps2c = 1'b1; tick(HP);
        check("busy_after_idle_glitch", 32'(busy), 32'd0);
        send_frame(8'hA5, good_par(8'hA5), 1'b1, DB + 3, 1'b1);

        // Reset mid-frame after five data bits.
        send_frame(8'h3B, 1'b0, 1'b1, 6, 1'b0);
        rst_n = 1'b0;
        model_dout = '0;
        tick(3);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        tick(2 * HP);
        send_frame(8'h1C, 1'b0, 1'b1, DB + 3, 1'b0);

        // Enable dropped for ten cycles mid-frame; the frame is abandoned.
        send_frame(8'h77, 1'b0, 1'b1, 4, 1'b0);
        en = 1'b0;
        tick(10);
        check("en_low_busy", 32'(busy), 32'd0);
        en = 1'b1;
        tick(TO + 2 * HP);
        check("en_restore_busy", 32'(busy), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1, DB + 3, 1'b0);

        // Randomized frames with occasional bad parity or stop bit.
        for (int k = 0; k < 20; k++) begin
            code = 8'($urandom_range(0, 255));
            par  = good_par(code) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(code, par, stop, DB + 3, 1'b0);
        end

        wait_drain(200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
